wb_regfile: RTL
===============

# wb_regfile

Architectural state sink at the far end of the MEM/WB pipeline register: a 32×32-bit general register file plus the HI/LO special registers.
- Accepts the registered writeback bundle each cycle; commits GPR and HI/LO writes on the rising clock edge.
- Serves two GPR read ports and the HI/LO read port to the decode/execute stages.
- Read results include same-cycle write bypass, so the pipeline needs no WB→ID forwarding path.

## Interface
Parameters:
- DATA_W, 32, width of every register
- ADDR_W, 5, GPR address width (2^ADDR_W registers)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-low reset
- writeEnable_i  input  1  GPR write strobe from MEM/WB
- writeAddr_i  input  ADDR_W  GPR write address
- writeData_i  input  DATA_W  GPR write data
- writeHILO_i  input  2  bit1 = write HI, bit0 = write LO
- HI_data_i  input  DATA_W  HI write data
- LO_data_i  input  DATA_W  LO write data
- readEnable1_i  input  1  port-1 read enable
- readAddr1_i  input  ADDR_W  port-1 address
- readData1_o  output  DATA_W  port-1 data
- readEnable2_i  input  1  port-2 read enable
- readAddr2_i  input  ADDR_W  port-2 address
- readData2_o  output  DATA_W  port-2 data
- HI_o  output  DATA_W  current HI, with bypass
- LO_o  output  DATA_W  current LO, with bypass

## Operation
Reset:
- rst low clears all 32 GPRs, HI and LO to 0 immediately, independent of clk.
- While rst is low, all outputs read 0 and the bypass is disabled.

Writes:
- On a rising edge with rst high and writeEnable_i = 1, GPR[writeAddr_i] ← writeData_i.
- A write to address 0 is discarded; GPR0 always reads 0.
- writeHILO_i[1] = 1 → HI ← HI_data_i. writeHILO_i[0] = 1 → LO ← LO_data_i.
- The HI and LO writes are independent; 2'b11 writes both in the same edge.

GPR reads (combinational), evaluated in this priority order:
1. rst low, or readEnableN_i = 0 → 0.
2. readAddrN_i = 0 → 0.
3. writeEnable_i = 1 and writeAddr_i = readAddrN_i → writeData_i (bypass).
4. Otherwise → stored GPR[readAddrN_i].

HI/LO reads:
- HI_o = HI_data_i when writeHILO_i[1] = 1, else stored HI.
- LO_o uses the same rule with writeHILO_i[0] and LO_data_i.

Both read ports may address the same register; each applies the bypass independently.

## Timing
- Write latency: 1 edge. Data is visible from storage on the cycle after the edge, and through the bypass in the same cycle as the write.
- Read latency: 0 cycles, combinational from address, enable and write-side inputs.
- No stall input. A MEM/WB bubble arrives as writeEnable_i = 0 / writeHILO_i = 0 and produces no write.
- If rst is asserted mid-cycle while a write is presented, the write is lost and the clear takes effect at once.
- On rst deassertion, writes resume at the first rising edge that sees rst high.

## Structure
Shared package (cpu_defs), shared with the MEM/WB and ID stages:
- ZERO_WORD
- REG_NUM = 32
- DATA_W / ADDR_W constants
- writeHILO bit indices: HILO_HI = 1, HILO_LO = 0

Sub-module:
- hilo_reg: HI/LO storage plus bypass, instantiated once.
- GPR array and its two read muxes stay in wb_regfile.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, then pulse rst low asynchronously between edges → readData1_o (addr 5, en 1) reads 0 immediately, and stays 0 after rst rises.
- Write then read: write r7 = 0x12345678; next cycle read port 2 addr 7 → 0x12345678; with readEnable2_i = 0 → 0.
- Same-cycle bypass: write r3 = 0xAAAA5555 while both ports read addr 3 → both outputs 0xAAAA5555 in that cycle, stored value unchanged until the edge.
- r0 protection: write r0 = 0xFFFFFFFF with readAddr1_i = 0 → readData1_o = 0, both in that cycle and after the edge.
- HI/LO: writeHILO_i = 2'b10, HI_data_i = 0x1, LO_data_i = 0x2 → HI_o = 1 bypassed and LO_o unchanged (0). Next writeHILO_i = 2'b11 with 0x3 / 0x4 → after the edge HI = 3, LO = 4.
- Bubble: writeEnable_i = 0, writeHILO_i = 0 with nonzero data and address → no storage change over 4 cycles.

Source files
------------

// File: rtl/cpu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_defs                                                   |
// | Purpose : Datapath constants shared by the MEM/WB, ID and writeback  |
// |           register-file logic.                                       |
// | Ports   : n/a (package)                                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_defs;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // Bit positions inside the 2-bit writeHILO strobe
  localparam int HILO_HI = 1;
  localparam int HILO_LO = 0;

endpackage
`default_nettype wire

// File: rtl/hilo_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hilo_reg                                                   |
// | Purpose : HI/LO special registers with same-cycle write bypass.      |
// | Ports   : clk, rst (async active-low), i_we[1:0] (bit1 HI, bit0 LO), |
// |           i_hi / i_lo write data, o_hi / o_lo current value.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hilo_reg
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_we,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_we[HILO_HI]) r_hi <= i_hi;
      if (i_we[HILO_LO]) r_lo <= i_lo;
    end
  end

  // Bypass is suppressed during reset so the outputs read 0 immediately.
  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (rst) begin
      o_hi = i_we[HILO_HI] ? i_hi : r_hi;
      o_lo = i_we[HILO_LO] ? i_lo : r_lo;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_regfile                                                 |
// | Purpose : 32-entry GPR file plus HI/LO, committed from the MEM/WB    |
// |           bundle, with two combinational GPR read ports and a        |
// |           same-cycle write bypass on every read path.                |
// | Ports   : clk, rst (async active-low)                                |
// |           writeEnable_i/writeAddr_i/writeData_i  GPR write           |
// |           writeHILO_i/HI_data_i/LO_data_i        HI/LO write         |
// |           readEnableN_i/readAddrN_i/readDataN_o  GPR read ports 1,2  |
// |           HI_o/LO_o                              HI/LO read          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module wb_regfile
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeEnable_i,
  input  logic [ADDR_W-1:0] writeAddr_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic [1:0]        writeHILO_i,
  input  logic [DATA_W-1:0] HI_data_i,
  input  logic [DATA_W-1:0] LO_data_i,
  input  logic              readEnable1_i,
  input  logic [ADDR_W-1:0] readAddr1_i,
  output logic [DATA_W-1:0] readData1_o,
  input  logic              readEnable2_i,
  input  logic [ADDR_W-1:0] readAddr2_i,
  output logic [DATA_W-1:0] readData2_o,
  output logic [DATA_W-1:0] HI_o,
  output logic [DATA_W-1:0] LO_o
);

  localparam int c_NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_gpr [c_NREGS];

  // GPR0 is never written, so it holds its reset value of 0 forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_NREGS; i++) r_gpr[i] <= '0;
    end else if (writeEnable_i && (writeAddr_i != '0)) begin
      r_gpr[writeAddr_i] <= writeData_i;
    end
  end

  // Read priority: reset/disabled, r0, bypass from the write port, storage.
  function automatic logic [DATA_W-1:0] f_read(input logic              en,
                                               input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!rst || !en)                               v = '0;
    else if (addr == '0)                           v = '0;
    else if (writeEnable_i && writeAddr_i == addr) v = writeData_i;
    else                                           v = r_gpr[addr];
    return v;
  endfunction

  always_comb begin
    readData1_o = f_read(readEnable1_i, readAddr1_i);
    readData2_o = f_read(readEnable2_i, readAddr2_i);
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .i_we (writeHILO_i),
    .i_hi (HI_data_i),
    .i_lo (LO_data_i),
    .o_hi (HI_o),
    .o_lo (LO_o)
  );

endmodule
`default_nettype wire
